io_intc: RTL

- Parametrised N-channel interrupt controller on the I/O register bus (A/WD/WE/RE/RD style), generalising the single INT_BTN interrupt source.
- Collects external interrupt lines, applies per-channel polarity, edge/level mode and mask, and latches pending state.
- Drives one registered interrupt request to CP0 and offers a priority-encoded claim register.

---
 rtl/intc_pkg.sv | 28 ++
 rtl/intc_sync.sv | 26 ++
 rtl/io_intc.sv | 137 +++++++++++++
 3 files changed

// File: rtl/intc_pkg.sv
// Shared constants and helpers for the io_intc interrupt controller:
// register word addresses, claim word layout and the priority encoder.
package intc_pkg;

  localparam int MAX_CH = 32;

  localparam logic [3:0] INTC_RAW   = 4'd0;
  localparam logic [3:0] INTC_PEND  = 4'd1;
  localparam logic [3:0] INTC_MASK  = 4'd2;
  localparam logic [3:0] INTC_MODE  = 4'd3;
  localparam logic [3:0] INTC_POL   = 4'd4;
  localparam logic [3:0] INTC_CLAIM = 4'd5;
  localparam logic [3:0] INTC_SOFT  = 4'd6;

  localparam int CLAIM_VALID_BIT = 31;
  localparam int CLAIM_ID_W      = 5;

  // Lowest set index wins; returns 0 when nothing is set (callers qualify with |v).
  function automatic logic [CLAIM_ID_W-1:0] prio_enc(input logic [MAX_CH-1:0] v);
    logic [CLAIM_ID_W-1:0] id;
    id = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (v[i]) id = CLAIM_ID_W'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/intc_sync.sv
// W-bit, DEPTH-stage flop synchroniser for asynchronous interrupt sources.
module intc_sync #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg [DEPTH];

  // Shift the raw inputs through DEPTH flops; all stages clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[DEPTH-1];

endmodule

// File: rtl/io_intc.sv
// N-channel interrupt controller on the I/O register bus.
// Per-channel polarity, edge/level mode and mask; registered INT/INT_ID to CP0
// plus a combinational priority claim register whose read (RE) acknowledges
// the winning edge channel.
// Build option: define INTC_SYNC_EN to put a SYNC_STAGES-deep synchroniser on
// every IRQ_IN bit; otherwise IRQ_IN is assumed synchronous to CLK.
module io_intc
  import intc_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N_CH-1:0] IRQ_IN,
  input  logic [3:0]      A,
  input  logic [31:0]     WD,
  input  logic            WE,
  input  logic            RE,
  output logic [31:0]     RD,
  output logic            INT,
  output logic [4:0]      INT_ID
);

  logic [N_CH-1:0] irq_s;
  logic [N_CH-1:0] s;
  logic [N_CH-1:0] prev_q;
  logic [N_CH-1:0] mask_q;
  logic [N_CH-1:0] mode_q;
  logic [N_CH-1:0] pol_q;
  logic [N_CH-1:0] pend_q;
  logic [N_CH-1:0] pend_d;
  logic [N_CH-1:0] active;
  logic [N_CH-1:0] wd_ch;
  logic [N_CH-1:0] w1c;
  logic [N_CH-1:0] soft_set;
  logic [N_CH-1:0] claim_clr;
  logic [N_CH-1:0] edge_set;
  logic [N_CH-1:0] edge_clr;
  logic            claim_valid;
  logic [CLAIM_ID_W-1:0] claim_id;
  logic [31:0]     claim_word;
  logic            int_q;
  logic [4:0]      int_id_q;
  logic            unused_wd;

`ifdef INTC_SYNC_EN
  intc_sync #(
    .W     (N_CH),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (IRQ_IN),
    .q   (irq_s)
  );
`else
  localparam int unused_sync_stages = SYNC_STAGES;
  assign irq_s = IRQ_IN;
`endif

  assign unused_wd = ^WD;
  assign wd_ch     = WD[N_CH-1:0];
  assign s         = irq_s ^ pol_q;

  assign active      = pend_q & mask_q;
  assign claim_valid = |active;
  assign claim_id    = prio_enc(MAX_CH'(active));

  assign w1c       = (WE && A == INTC_PEND) ? wd_ch : '0;
  assign soft_set  = (WE && A == INTC_SOFT) ? wd_ch : '0;
  assign claim_clr = (RE && A == INTC_CLAIM && claim_valid) ? (N_CH'(1) << claim_id) : '0;

  // Edge channels: set beats clear; level channels simply follow s.
  assign edge_set = (s & ~prev_q) | soft_set;
  assign edge_clr = w1c | claim_clr;
  assign pend_d   = (mode_q & ((pend_q & ~edge_clr) | edge_set)) | (~mode_q & s);

  // Edge history and pending latch.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      prev_q <= s;
      pend_q <= pend_d;
    end
  end

  // Software-writable configuration registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mask_q <= '0;
      mode_q <= '0;
      pol_q  <= '0;
    end else if (WE) begin
      case (A)
        INTC_MASK: mask_q <= wd_ch;
        INTC_MODE: mode_q <= wd_ch;
        INTC_POL:  pol_q  <= wd_ch;
        default: ;
      endcase
    end
  end

  // Registered request and winning index toward CP0.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      int_q    <= 1'b0;
      int_id_q <= '0;
    end else begin
      int_q    <= claim_valid;
      int_id_q <= claim_id;
    end
  end

  // Read mux; unused addresses and bits above N_CH read zero.
  always_comb begin
    claim_word                  = '0;
    claim_word[CLAIM_VALID_BIT] = claim_valid;
    claim_word[CLAIM_ID_W-1:0]  = claim_id;
    RD = '0;
    case (A)
      INTC_RAW:   RD = 32'(s);
      INTC_PEND:  RD = 32'(pend_q);
      INTC_MASK:  RD = 32'(mask_q);
      INTC_MODE:  RD = 32'(mode_q);
      INTC_POL:   RD = 32'(pol_q);
      INTC_CLAIM: RD = claim_word;
      default:    RD = '0;
    endcase
  end

  assign INT    = int_q;
  assign INT_ID = int_id_q;

endmodule
